i2c_master_byte_engine: RTL
===========================

Name: i2c_master_byte_engine

Overview:
- Synthesizable, parametrised I2C master byte engine: successor to the single-bus, open-drain I2C master drive model.
- Executes START / STOP / repeated-START / byte WRITE / byte READ commands on one of NUM_CH open-drain buses. Generates SCL timing from a quarter-period divider and samples ACK/data.
- Sits between a command/response register front-end and the chip's open-drain pad cells.

Parameters:
- NUM_CH, 2, number of independent I2C buses (1..8)
- CH_W, 1, channel-select width, clog2(NUM_CH) (min 1)
- QTR_DIV, 125, clk cycles per SCL quarter-period (>=2)
- DIV_W, 8, divider counter width (must hold QTR_DIV-1)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  engine idle, command accepted when valid&&ready
- cmd_op  input  3  0=START 1=STOP 2=WRITE 3=READ 4=RSTART, 5..7 illegal
- cmd_ch  input  CH_W  target bus, latched at accept
- cmd_wdata  input  8  WRITE byte, MSB first
- cmd_mack  input  1  master ACK bit driven after READ (0=ACK, 1=NACK)
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  8  READ byte (held until next READ completes)
- rsp_nack  output  1  slave ACK bit sampled on WRITE (1=NACK)
- rsp_err  output  1  illegal op flag, valid with rsp_valid
- busy  output  1  command in progress
- scl_oen  output  NUM_CH  1=release SCL (pad pulls high), 0=drive low
- sda_oen  output  NUM_CH  1=release SDA, 0=drive low
- scl_i  input  NUM_CH  SCL pad readback
- sda_i  input  NUM_CH  SDA pad readback

Behaviour:
- Reset (synchronous, next edge, also mid-command): all scl_oen/sda_oen=all-ones, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_nack=0, rsp_err=0. Command aborted, no response.
- Unselected channels: oen bits held 1 at all times.
- FSM states: IDLE, START, STOP, BIT, DONE.
  - IDLE: cmd_ready=1. Accept moves to the op state on the next cycle, busy=1, cmd_ready=0.
  - Illegal op: DONE directly. rsp_valid the cycle after accept, rsp_err=1, no bus change.
- Timing: each phase lasts exactly QTR_DIV cycles (divider counts 0..QTR_DIV-1). The command starts the cycle after accept.
  - Phase counts: START/RSTART/STOP=4, WRITE/READ=36 (9 bits x 4).
  - DONE is 1 cycle: rsp_valid=1, then IDLE. rsp_valid rises 1+phases*QTR_DIV cycles after the accept edge.
- START/RSTART: q0 sda=rel, scl=rel; q1 hold; q2 sda=low; q3 scl=low.
- STOP: q0 sda=low, scl=low; q1 scl=rel; q2 hold; q3 sda=rel.
- Bit (SCL low on entry):
  - q0 set SDA, with SCL low.
  - q1 scl=rel.
  - q2 hold; sample sda_i[ch] on the last cycle of q2.
  - q3 scl=low.
- WRITE: bits 7..0 drive cmd_wdata, where bit=1 releases SDA. Bit 9 releases SDA; its sample goes to rsp_nack.
- READ: bits 1..8 release SDA and shift samples into rsp_rdata (MSB first). Bit 9 drives cmd_mack.
- Bus state between commands: after START/RSTART/WRITE/READ, SCL stays low and SDA keeps its last value. After STOP, both are released.
- rsp_nack updates only on WRITE. rsp_rdata updates only on READ.
- No sequencing checks: WRITE without a prior START executes as commanded.
- cmd_valid while busy is ignored (cmd_ready=0).

Optional Feature:
- Macro I2C_MASTER_CLK_STRETCH_EN.
- Defined: during q1 and q2 of bits, and q1 of STOP/START, the divider freezes while scl_i[ch]==0 (slave stretching). Counting resumes the first cycle scl_i[ch]==1. Added latency equals the stretch duration.
- Undefined: scl_i is ignored and timing is fixed.

Test Plan:
- QTR_DIV=4, accept START on ch1 at cycle T:
  - sda_oen[1] falls at T+9 and scl_oen[1] falls at T+13.
  - rsp_valid at T+17.
  - ch0 oen stays 11.
- START then WRITE 0xA5, slave pulls sda_i low in bit 9:
  - SDA pattern on SCL high phases is 1,0,1,0,0,1,0,1.
  - rsp_valid 145 cycles after accept, rsp_nack=0.
- READ with slave bits 0x3C, cmd_mack=1:
  - rsp_rdata=0x3C, sda_oen released during bit 9, rsp_nack unchanged.
- cmd_op=6:
  - rsp_valid the next cycle, rsp_err=1, oen unchanged, cmd_ready back to 1 the cycle after.
- rst asserted mid-WRITE (phase 15):
  - Next edge: all oen=1, busy=0, no rsp_valid.
  - A new START is accepted normally.
- With I2C_MASTER_CLK_STRETCH_EN, hold scl_i low 20 cycles in bit 3 q1:
  - WRITE completes 20 cycles later (rsp_valid at accept+165).
  - Without the macro, completes at accept+145.

Source files
------------

// File: rtl/i2c_master_byte_engine.sv
// I2C master byte engine: runs START / STOP / repeated-START / byte WRITE / byte READ
// on one of NUM_CH open-drain buses. SCL timing comes from a quarter-period divider.
// The engine waits in IDLE for one extra cycle after each response, so cmd_ready
// rises one cycle after rsp_valid.
// Optional feature macro: I2C_MASTER_CLK_STRETCH_EN. When it is defined, the
// divider waits while a slave holds SCL low.
module i2c_master_byte_engine #(
    parameter int NUM_CH  = 2,
    parameter int CH_W    = 1,
    parameter int QTR_DIV = 125,
    parameter int DIV_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [7:0]        cmd_wdata,
    input  logic              cmd_mack,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_nack,
    output logic              rsp_err,
    output logic              busy,
    output logic [NUM_CH-1:0] scl_oen,
    output logic [NUM_CH-1:0] sda_oen,
    input  logic [NUM_CH-1:0] scl_i,
    input  logic [NUM_CH-1:0] sda_i
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_STOP  = 3'd2,
        ST_BIT   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] OP_START  = 3'd0;
    localparam logic [2:0] OP_STOP   = 3'd1;
    localparam logic [2:0] OP_WRITE  = 3'd2;
    localparam logic [2:0] OP_READ   = 3'd3;
    localparam logic [2:0] OP_RSTART = 3'd4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(QTR_DIV - 1);

    state_t            state_r, state_nx_s;
    logic [DIV_W-1:0]  div_r;
    logic [1:0]        qtr_r;
    logic [3:0]        bit_r;
    logic [2:0]        op_r;
    logic [CH_W-1:0]   ch_r;
    logic [7:0]        wdata_r;
    logic              mack_r;
    logic [7:0]        shift_r;
    logic              ack_r;
    logic              scl_lvl_r, sda_lvl_r, scl_nx_s, sda_nx_s;
    logic              accept_s, active_s, freeze_s, qtr_end_s, sample_s, bit_val_s;
    logic              cmd_ready_r, busy_r, rsp_valid_r, rsp_nack_r, rsp_err_r;
    logic [7:0]        rsp_rdata_r;
    logic [NUM_CH-1:0] scl_oen_r, sda_oen_r;

    // Release every line except the selected channel, which gets the requested level.
    function automatic logic [NUM_CH-1:0] line_mask(input logic lvl, input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] m;
        m     = {NUM_CH{1'b1}};
        m[ch] = lvl;
        return m;
    endfunction

    assign accept_s  = cmd_valid && cmd_ready_r && (state_r == ST_IDLE);
    assign active_s  = (state_r == ST_START) || (state_r == ST_STOP) || (state_r == ST_BIT);
    assign qtr_end_s = active_s && (div_r == DIV_LAST) && !freeze_s;
    assign sample_s  = (state_r == ST_BIT) && (qtr_r == 2'd2) && qtr_end_s;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    // Hold the divider while SCL has been released by us but a slave keeps it low.
    always_comb begin
        freeze_s = 1'b0;
        if (scl_oen_r[ch_r] && !scl_i[ch_r]) begin
            case (state_r)
                ST_BIT:            freeze_s = (qtr_r == 2'd1) || (qtr_r == 2'd2);
                ST_START, ST_STOP: freeze_s = (qtr_r == 2'd1);
                default:           freeze_s = 1'b0;
            endcase
        end else begin
            freeze_s = 1'b0;
        end
    end
`else
    logic unused_scl_s;
    assign freeze_s     = 1'b0;
    assign unused_scl_s = ^scl_i;
`endif

    // SDA level for the current bit: write data then released ACK slot, or released read bits then master ACK.
    always_comb begin
        bit_val_s = 1'b1;
        if (op_r == OP_WRITE) begin
            bit_val_s = (bit_r < 4'd8) ? wdata_r[3'd7 - bit_r[2:0]] : 1'b1;
        end else begin
            bit_val_s = (bit_r < 4'd8) ? 1'b1 : mack_r;
        end
    end

    // Next state and next bus levels; levels hold whenever no phase drives them.
    always_comb begin
        state_nx_s = state_r;
        scl_nx_s   = scl_lvl_r;
        sda_nx_s   = sda_lvl_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_START, OP_RSTART: state_nx_s = ST_START;
                        OP_STOP:             state_nx_s = ST_STOP;
                        OP_WRITE, OP_READ:   state_nx_s = ST_BIT;
                        default:             state_nx_s = ST_DONE;
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                scl_nx_s   = (qtr_r != 2'd3);
                sda_nx_s   = (qtr_r < 2'd2);
                state_nx_s = (qtr_end_s && qtr_r == 2'd3) ? ST_DONE : ST_START;
            end
            ST_STOP: begin
                scl_nx_s   = (qtr_r != 2'd0);
                sda_nx_s   = (qtr_r == 2'd3);
                state_nx_s = (qtr_end_s && qtr_r == 2'd3) ? ST_DONE : ST_STOP;
            end
            ST_BIT: begin
                scl_nx_s   = (qtr_r == 2'd1) || (qtr_r == 2'd2);
                sda_nx_s   = bit_val_s;
                state_nx_s = (qtr_end_s && qtr_r == 2'd3 && bit_r == 4'd8) ? ST_DONE : ST_BIT;
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nx_s;
    end

    // Command latch, quarter/bit counters, bus level tracking and sampled data.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r     <= '0;
            qtr_r     <= 2'd0;
            bit_r     <= 4'd0;
            op_r      <= 3'd0;
            ch_r      <= '0;
            wdata_r   <= 8'd0;
            mack_r    <= 1'b0;
            shift_r   <= 8'd0;
            ack_r     <= 1'b0;
            scl_lvl_r <= 1'b1;
            sda_lvl_r <= 1'b1;
        end else begin
            scl_lvl_r <= scl_nx_s;
            sda_lvl_r <= sda_nx_s;
            if (accept_s) begin
                div_r   <= '0;
                qtr_r   <= 2'd0;
                bit_r   <= 4'd0;
                op_r    <= cmd_op;
                wdata_r <= cmd_wdata;
                mack_r  <= cmd_mack;
                // Illegal ops must not move the selected bus.
                if (cmd_op <= OP_RSTART) ch_r <= cmd_ch;
            end else if (active_s && !freeze_s) begin
                if (div_r == DIV_LAST) begin
                    div_r <= '0;
                    qtr_r <= qtr_r + 2'd1;
                    if (qtr_r == 2'd3) bit_r <= bit_r + 4'd1;
                end else begin
                    div_r <= div_r + DIV_W'(1);
                end
            end
            if (sample_s) begin
                if (bit_r < 4'd8) shift_r <= {shift_r[6:0], sda_i[ch_r]};
                else              ack_r   <= sda_i[ch_r];
            end
        end
    end

    // Registered handshake, response and pad-enable outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 8'd0;
            rsp_nack_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
            scl_oen_r   <= {NUM_CH{1'b1}};
            sda_oen_r   <= {NUM_CH{1'b1}};
        end else begin
            cmd_ready_r <= (state_r == ST_IDLE) && !accept_s;
            busy_r      <= !((state_r == ST_IDLE) && !accept_s);
            rsp_valid_r <= (state_r == ST_DONE);
            rsp_err_r   <= (state_r == ST_DONE) && (op_r > OP_RSTART);
            if (state_r == ST_DONE && op_r == OP_WRITE) rsp_nack_r  <= ack_r;
            if (state_r == ST_DONE && op_r == OP_READ)  rsp_rdata_r <= shift_r;
            scl_oen_r   <= line_mask(scl_nx_s, ch_r);
            sda_oen_r   <= line_mask(sda_nx_s, ch_r);
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_nack  = rsp_nack_r;
    assign rsp_err   = rsp_err_r;
    assign scl_oen   = scl_oen_r;
    assign sda_oen   = sda_oen_r;

endmodule
